minterm_scanner: RTL and testbench

Sequential truth-table reader for the team's gate-level combinational designs. On a start pulse it drives every input combination 0..2^N_IN−1 into a combinational function under test and samples its single output after a programmable settle time. It assembles the 16-bit (for N_IN=4) minterm mask and compares it against an expected mask. It is the hardware check that a NAND/NOR network implements its Σ/Π specification.

---
 rtl/minterm_pkg.sv | 21 ++
 rtl/minterm_scanner_settle_timer.sv | 36 +++
 rtl/minterm_scanner.sv | 134 +++++++++++++
 tb/tb_minterm_scanner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm scanner and its benches.
// Holds the FSM state encoding, mask-width helper and the legal settle range.
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_IN_MIN   = 1;
  localparam int unsigned N_IN_MAX   = 6;
  localparam int unsigned SETTLE_MIN = 0;
  localparam int unsigned SETTLE_MAX = 15;

  // Width of the minterm mask for an n-input function.
  function automatic int unsigned mask_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/minterm_scanner_settle_timer.sv
// Reusable 4-bit settle down-counter: load a delay, count down while enabled,
// and flag expiry once the count reaches zero.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/minterm_scanner.sv
// Sequential truth-table reader: walks every input combination of a
// combinational function, builds its minterm mask and diffs it against an expected mask.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter  int unsigned N_IN   = 4,
  parameter  int unsigned SETTLE = 1,
  localparam int unsigned M      = mask_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [M-1:0]    expected,
  output logic [N_IN-1:0] fn_in,
  input  logic            fn_out,
  output logic            busy,
  output logic            done,
  output logic [M-1:0]    mask,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            pass
);

  localparam logic [N_IN-1:0] LAST_IDX  = N_IN'(M - 1);
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE   = (N_IN + 1)'(1);
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [M-1:0]      exp_q, exp_d;
  logic [M-1:0]      mask_q, mask_d;
  logic [N_IN:0]     mm_cnt_q, mm_cnt_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic              pass_q, pass_d;

  logic              accept;
  logic              sample;
  logic              settled;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept | sample),
    .load_val (SETTLE_LD),
    .en       (state_q == SCAN),
    .expired  (settled)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    mask_d       = mask_q;
    mm_cnt_d     = mm_cnt_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    accept       = 1'b0;
    sample       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept       = 1'b1;
          state_d      = SCAN;
          idx_d        = '0;
          exp_d        = expected;
          mask_d       = '0;
          mm_cnt_d     = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
        end
      end

      SCAN: begin
        if (settled) begin
          sample         = 1'b1;
          mask_d[idx_q]  = fn_out;
          if (fn_out != exp_q[idx_q]) begin
            mm_cnt_d = mm_cnt_q + CNT_ONE;
            if (mm_cnt_q == '0) begin
              first_fail_d = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            // Pass is computed from the final count so it is already valid in the done cycle.
            pass_d  = (mm_cnt_d == '0);
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      exp_q        <= '0;
      mask_q       <= '0;
      mm_cnt_q     <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      mask_q       <= mask_d;
      mm_cnt_q     <= mm_cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  // The function under test only sees a live index while scanning.
  assign fn_in        = (state_q == SCAN) ? idx_q : '0;
  assign busy         = (state_q == SCAN);
  assign done         = (state_q == DONE);
  assign mask         = mask_q;
  assign mismatch_cnt = mm_cnt_q;
  assign first_fail   = first_fail_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: two instances (SETTLE=1 and SETTLE=0)
// each driving a selectable gate-level function with hand-derived truth tables.
module tb_minterm_scanner;
  import minterm_pkg::*;

  localparam int N      = 4;
  localparam int M      = 16;
  localparam int WINDOW = M * (SETTLE_MAX + 1) + 4;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pass;
    logic [M-1:0]  mask;
    logic [N:0]    mm;
    logic [N-1:0]  ff;
    logic [N-1:0]  fn_in;
  } obs_t;

  logic clk;
  logic rst_n;

  logic          start_a, start_b;
  logic [M-1:0]  exp_a, exp_b;
  int            sel_a, sel_b;
  logic [N-1:0]  fn_in_a, fn_in_b;
  logic          fn_out_a, fn_out_b;
  logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [M-1:0]  mask_a, mask_b;
  logic [N:0]    mm_a, mm_b;
  logic [N-1:0]  ff_a, ff_b;

  int checks;
  int failures;

  minterm_scanner #(.N_IN(N), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
    .fn_in(fn_in_a), .fn_out(fn_out_a), .busy(busy_a), .done(done_a),
    .mask(mask_a), .mismatch_cnt(mm_a), .first_fail(ff_a), .pass(pass_a)
  );

  minterm_scanner #(.N_IN(N), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
    .fn_in(fn_in_b), .fn_out(fn_out_b), .busy(busy_b), .done(done_b),
    .mask(mask_b), .mismatch_cnt(mm_b), .first_fail(ff_b), .pass(pass_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Functions under test, minterm index = {a,b,c,d}.
  // 0: ab + cd            -> F888
  // 1: d' + ab'           -> 5F55
  // 2: d'(b' + c) + abc'd -> 6545
  function automatic logic eval_fn(input int sel, input logic [N-1:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    case (sel)
      0:       return (a & b) | (c & d);
      1:       return ~d | (a & ~b);
      2:       return (~d & (~b | c)) | (a & b & ~c & d);
      default: return 1'b0;
    endcase
  endfunction

  always_comb fn_out_a = eval_fn(sel_a, fn_in_a);
  always_comb fn_out_b = eval_fn(sel_b, fn_in_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic obs_t observe(input int w);
    obs_t o;
    if (w == 0) o = '{busy_a, done_a, pass_a, mask_a, mm_a, ff_a, fn_in_a};
    else        o = '{busy_b, done_b, pass_b, mask_b, mm_b, ff_b, fn_in_b};
    return o;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_exp(input int w, input logic [M-1:0] v);
    if (w == 0) exp_a = v; else exp_b = v;
  endtask

  task automatic set_fn(input int w, input int s);
    if (w == 0) sel_a = s; else sel_b = s;
  endtask

  task automatic check_zero(input string tag, input int w);
    obs_t o;
    o = observe(w);
    check({tag, "/busy"},  32'(o.busy),  0);
    check({tag, "/done"},  32'(o.done),  0);
    check({tag, "/pass"},  32'(o.pass),  0);
    check({tag, "/mask"},  32'(o.mask),  0);
    check({tag, "/mm"},    32'(o.mm),    0);
    check({tag, "/ff"},    32'(o.ff),    0);
    check({tag, "/fn_in"}, 32'(o.fn_in), 0);
  endtask

  // Starts a scan (start high in cycle 0), optionally perturbs inputs, and
  // watches a bounded window for the done pulse and the held results.
  task automatic run_scan(input string name, input int w, input int fsel,
                          input logic [M-1:0] exp_in, input int chg_cyc,
                          input logic [M-1:0] chg_val, input int rs_a, input int rs_b,
                          input int exp_done, input logic [M-1:0] exp_mask,
                          input logic [N:0] exp_mm, input logic [N-1:0] exp_ff,
                          input logic exp_pass);
    obs_t o;
    int   done_cnt;
    int   done_at;
    done_cnt = 0;
    done_at  = -1;
    set_fn(w, fsel);
    set_exp(w, exp_in);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      if (cyc == chg_cyc) set_exp(w, chg_val);
      set_start(w, (cyc == rs_a) || (cyc == rs_b));
      @(negedge clk);
      o = observe(w);
      if (cyc == 1) begin
        check({name, "/busy_c1"},  32'(o.busy),  1);
        check({name, "/fn_in_c1"}, 32'(o.fn_in), 0);
      end
      if (cyc == exp_done - 1) begin
        check({name, "/busy_last"},  32'(o.busy),  1);
        check({name, "/fn_in_last"}, 32'(o.fn_in), 32'(M - 1));
      end
      if (o.done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        check({name, "/busy_at_done"}, 32'(o.busy), 0);
        check({name, "/pass_at_done"}, 32'(o.pass), 32'(exp_pass));
        check({name, "/mask_at_done"}, 32'(o.mask), 32'(exp_mask));
      end
      @(posedge clk); #1;
    end
    set_start(w, 1'b0);
    o = observe(w);
    check({name, "/done_cycle"}, 32'(done_at),  32'(exp_done));
    check({name, "/done_count"}, 32'(done_cnt), 1);
    check({name, "/busy_after"}, 32'(o.busy),   0);
    check({name, "/mask"},       32'(o.mask),   32'(exp_mask));
    check({name, "/mm"},         32'(o.mm),     32'(exp_mm));
    check({name, "/ff"},         32'(o.ff),     32'(exp_ff));
    check({name, "/pass"},       32'(o.pass),   32'(exp_pass));
  endtask

  // Aborts a SETTLE=1 scan with reset at cycle 10 for two cycles.
  task automatic run_reset_abort();
    obs_t o;
    int   done_cnt;
    done_cnt = 0;
    set_fn(0, 0);
    set_exp(0, 16'hF888);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      if (cyc == 10) rst_n = 1'b0;
      if (cyc == 12) rst_n = 1'b1;
      @(negedge clk);
      o = observe(0);
      if (cyc == 9) check("abort/mask_before", 32'(o.mask), 32'h0008);
      if (cyc == 10 || cyc == 11) begin
        check_zero("abort_in_reset_a", 0);
        check_zero("abort_in_reset_b", 1);
      end
      if (o.done) done_cnt++;
      @(posedge clk); #1;
    end
    o = observe(0);
    check("abort/done_count", 32'(done_cnt), 0);
    check("abort/busy_after", 32'(o.busy),   0);
    check("abort/mask_after", 32'(o.mask),   0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    exp_a    = '0;
    exp_b    = '0;
    sel_a    = 0;
    sel_b    = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_a", 0);
    check_zero("reset_b", 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //        name        w fn exp       chg chgval    rs_a rs_b done  mask      mm     ff     pass
    run_scan("ab_cd_s1",  0, 0, 16'hF888, -1, 16'h0000, -1,  -1,  33, 16'hF888, 5'd0,  4'd0, 1'b1);
    run_scan("sop_s0",    1, 1, 16'h5F55, -1, 16'h0000, -1,  -1,  17, 16'h5F55, 5'd0,  4'd0, 1'b1);
    run_scan("bad_bit0",  0, 2, 16'h6544, -1, 16'h0000, -1,  -1,  33, 16'h6545, 5'd1,  4'd0, 1'b0);
    run_scan("exp_chg",   0, 0, 16'hF880,  5, 16'hF888, -1,  -1,  33, 16'hF888, 5'd1,  4'd3, 1'b0);
    run_scan("restart",   0, 0, 16'hF888, -1, 16'h0000,  4,  20,  33, 16'hF888, 5'd0,  4'd0, 1'b1);
    run_scan("all_bad",   1, 0, 16'h0777, -1, 16'h0000, 17,  -1,  17, 16'hF888, 5'd16, 4'd0, 1'b0);
    run_scan("multi_s0",  1, 2, 16'h6505, -1, 16'h0000, -1,  -1,  17, 16'h6545, 5'd1,  4'd6, 1'b0);

    run_reset_abort();
    run_scan("post_rst",  0, 2, 16'h6545, -1, 16'h0000, -1,  -1,  33, 16'h6545, 5'd0,  4'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
